// File: rtl/sd_init_ctrl.sv
// sd_init_ctrl: SD card power-up and identification sequencer.
// Keeps the card on the 200 kHz identification clock and walks it through
// CMD0, CMD8, CMD55/ACMD41, CMD2, CMD3 and CMD7 into transfer state.
// It then switches clk_mod to the 24 MHz transfer clock.
// Only one command is outstanding at a time on the command engine.
// Optional macro SD_INIT_CMD16_EN: issue CMD16 (512-byte block length) after
// CMD7 for standard-capacity cards.
module sd_init_ctrl #(
  parameter int POWERUP_CYCLES = 17760,
  parameter int ACMD41_RETRY   = 1000,
  parameter int SWITCH_GUARD   = 16
) (
  input  logic        clk48mhz,
  input  logic        rst_n,
  input  logic        start,
  output logic        clk_mod,
  output logic        cmd_req,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  input  logic        cmd_done,
  input  logic        cmd_timeout,
  input  logic        cmd_crc_err,
  input  logic [31:0] cmd_resp,
  output logic        init_busy,
  output logic        init_done,
  output logic        init_err,
  output logic [2:0]  err_code,
  output logic        sdhc,
  output logic [15:0] rca
);

  localparam int CNT_MAX = (POWERUP_CYCLES > SWITCH_GUARD) ? POWERUP_CYCLES : SWITCH_GUARD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RETRY_W = $clog2(ACMD41_RETRY + 1);

  localparam logic [CNT_W-1:0]   PWRUP_LAST  = CNT_W'(POWERUP_CYCLES - 1);
  localparam logic [CNT_W-1:0]   GUARD_LAST  = CNT_W'(SWITCH_GUARD - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(ACMD41_RETRY);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_PWRUP  = 4'd1;
  localparam logic [3:0] S_CMD0   = 4'd2;
  localparam logic [3:0] S_CMD8   = 4'd3;
  localparam logic [3:0] S_CMD55  = 4'd4;
  localparam logic [3:0] S_ACMD41 = 4'd5;
  localparam logic [3:0] S_CMD2   = 4'd6;
  localparam logic [3:0] S_CMD3   = 4'd7;
  localparam logic [3:0] S_CMD7   = 4'd8;
`ifdef SD_INIT_CMD16_EN
  localparam logic [3:0] S_CMD16  = 4'd9;
`endif
  localparam logic [3:0] S_GUARD  = 4'd10;
  localparam logic [3:0] S_DONE   = 4'd11;
  localparam logic [3:0] S_ERR    = 4'd12;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_ECHO    = 3'd1;
  localparam logic [2:0] ERR_RETRY   = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT = 3'd3;
  localparam logic [2:0] ERR_CRC     = 3'd4;

  logic [3:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               v2_q, v2_d;
  logic               clkMod_q, clkMod_d;
  logic [2:0]         errCode_q, errCode_d;
  logic               sdhc_q, sdhc_d;
  logic [15:0]        rca_q, rca_d;
  logic               cmdReq_q, cmdReq_d;
  logic [5:0]         cmdIndex_q, cmdIndex_d;
  logic [31:0]        cmdArg_q, cmdArg_d;
  logic               goErr;
  logic [2:0]         errSel;
  logic               unusedResp;

  // Response bits [15:12] carry no information this sequencer needs.
  assign unusedResp = ^cmd_resp[15:12];

  // Sequencer next-state: a timeout always outranks a done pulse in the same cycle,
  // and any failing branch raises goErr so the ERR entry is handled in one place.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retry_d   = retry_q;
    v2_d      = v2_q;
    clkMod_d  = clkMod_q;
    errCode_d = errCode_q;
    sdhc_d    = sdhc_q;
    rca_d     = rca_q;
    goErr     = 1'b0;
    errSel    = ERR_NONE;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d   = S_PWRUP;
          cnt_d     = '0;
          retry_d   = '0;
          v2_d      = 1'b0;
          clkMod_d  = 1'b0;
          errCode_d = ERR_NONE;
          sdhc_d    = 1'b0;
          rca_d     = 16'h0;
        end
      end
      S_PWRUP: begin
        if (cnt_q == PWRUP_LAST) begin
          cnt_d   = '0;
          state_d = S_CMD0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CMD0: begin
        if (cmd_timeout) begin
          goErr  = 1'b1;
          errSel = ERR_TIMEOUT;
        end else if (cmd_done) begin
          state_d = S_CMD8;
        end
      end
      S_CMD8: begin
        if (cmd_timeout) begin
          v2_d    = 1'b0;
          state_d = S_CMD55;
        end else if (cmd_done) begin
          if (cmd_crc_err) begin
            goErr  = 1'b1;
            errSel = ERR_CRC;
          end else if (cmd_resp[11:0] == 12'h1AA) begin
            v2_d    = 1'b1;
            state_d = S_CMD55;
          end else begin
            goErr  = 1'b1;
            errSel = ERR_ECHO;
          end
        end
      end
      S_CMD55: begin
        if (cmd_timeout) begin
          goErr  = 1'b1;
          errSel = ERR_TIMEOUT;
        end else if (cmd_done) begin
          if (cmd_crc_err) begin
            goErr  = 1'b1;
            errSel = ERR_CRC;
          end else begin
            state_d = S_ACMD41;
          end
        end
      end
      S_ACMD41: begin
        if (cmd_timeout) begin
          goErr  = 1'b1;
          errSel = ERR_TIMEOUT;
        end else if (cmd_done) begin
          if (cmd_resp[31]) begin
            sdhc_d  = cmd_resp[30];
            state_d = S_CMD2;
          end else begin
            retry_d = retry_q + 1'b1;
            if (retry_d == RETRY_LIMIT) begin
              goErr  = 1'b1;
              errSel = ERR_RETRY;
            end else begin
              state_d = S_CMD55;
            end
          end
        end
      end
      S_CMD2: begin
        if (cmd_timeout) begin
          goErr  = 1'b1;
          errSel = ERR_TIMEOUT;
        end else if (cmd_done) begin
          state_d = S_CMD3;
        end
      end
      S_CMD3: begin
        if (cmd_timeout) begin
          goErr  = 1'b1;
          errSel = ERR_TIMEOUT;
        end else if (cmd_done) begin
          if (cmd_crc_err) begin
            goErr  = 1'b1;
            errSel = ERR_CRC;
          end else begin
            rca_d   = cmd_resp[31:16];
            state_d = S_CMD7;
          end
        end
      end
      S_CMD7: begin
        if (cmd_timeout) begin
          goErr  = 1'b1;
          errSel = ERR_TIMEOUT;
        end else if (cmd_done) begin
          if (cmd_crc_err) begin
            goErr  = 1'b1;
            errSel = ERR_CRC;
          end else begin
            cnt_d = '0;
`ifdef SD_INIT_CMD16_EN
            state_d = sdhc_q ? S_GUARD : S_CMD16;
`else
            state_d = S_GUARD;
`endif
          end
        end
      end
`ifdef SD_INIT_CMD16_EN
      S_CMD16: begin
        if (cmd_timeout) begin
          goErr  = 1'b1;
          errSel = ERR_TIMEOUT;
        end else if (cmd_done) begin
          if (cmd_crc_err) begin
            goErr  = 1'b1;
            errSel = ERR_CRC;
          end else begin
            cnt_d   = '0;
            state_d = S_GUARD;
          end
        end
      end
`endif
      S_GUARD: begin
        if (cnt_q == GUARD_LAST) begin
          state_d  = S_DONE;
          clkMod_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (goErr) begin
      state_d   = S_ERR;
      errCode_d = errSel;
      clkMod_d  = 1'b0;
    end
  end

  // Command request follows the state being entered, so a new index/arg appears
  // together with cmd_req on the first cycle of each command state.
  always_comb begin
    cmdReq_d   = 1'b0;
    cmdIndex_d = cmdIndex_q;
    cmdArg_d   = cmdArg_q;
    case (state_d)
      S_CMD0:   begin cmdReq_d = 1'b1; cmdIndex_d = 6'd0;  cmdArg_d = 32'h0; end
      S_CMD8:   begin cmdReq_d = 1'b1; cmdIndex_d = 6'd8;  cmdArg_d = 32'h0000_01AA; end
      S_CMD55:  begin cmdReq_d = 1'b1; cmdIndex_d = 6'd55; cmdArg_d = 32'h0; end
      S_ACMD41: begin
        cmdReq_d   = 1'b1;
        cmdIndex_d = 6'd41;
        cmdArg_d   = v2_d ? 32'h40FF_8000 : 32'h00FF_8000;
      end
      S_CMD2:   begin cmdReq_d = 1'b1; cmdIndex_d = 6'd2;  cmdArg_d = 32'h0; end
      S_CMD3:   begin cmdReq_d = 1'b1; cmdIndex_d = 6'd3;  cmdArg_d = 32'h0; end
      S_CMD7:   begin cmdReq_d = 1'b1; cmdIndex_d = 6'd7;  cmdArg_d = {rca_d, 16'h0}; end
`ifdef SD_INIT_CMD16_EN
      S_CMD16:  begin cmdReq_d = 1'b1; cmdIndex_d = 6'd16; cmdArg_d = 32'h0000_0200; end
`endif
      default: ;
    endcase
  end

  // State and output registers; reset aborts any sequence in progress.
  always_ff @(posedge clk48mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      retry_q    <= '0;
      v2_q       <= 1'b0;
      clkMod_q   <= 1'b0;
      errCode_q  <= ERR_NONE;
      sdhc_q     <= 1'b0;
      rca_q      <= 16'h0;
      cmdReq_q   <= 1'b0;
      cmdIndex_q <= 6'd0;
      cmdArg_q   <= 32'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      v2_q       <= v2_d;
      clkMod_q   <= clkMod_d;
      errCode_q  <= errCode_d;
      sdhc_q     <= sdhc_d;
      rca_q      <= rca_d;
      cmdReq_q   <= cmdReq_d;
      cmdIndex_q <= cmdIndex_d;
      cmdArg_q   <= cmdArg_d;
    end
  end

  assign clk_mod   = clkMod_q;
  assign cmd_req   = cmdReq_q;
  assign cmd_index = cmdIndex_q;
  assign cmd_arg   = cmdArg_q;
  assign init_busy = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
  assign init_done = (state_q == S_DONE);
  assign init_err  = (state_q == S_ERR);
  assign err_code  = errCode_q;
  assign sdhc      = sdhc_q;
  assign rca       = rca_q;

endmodule

// File: tb/tb_sd_init_ctrl.sv
// tb_sd_init_ctrl: directed bench for the SD init sequencer.
// A table of card-behaviour scenarios drives a simple command-engine responder.
// Hand-written sequences follow for start-while-busy and reset during ACMD41.
module tb_sd_init_ctrl;

  localparam int PWR    = 20;
  localparam int RETRY  = 4;
  localparam int GUARD  = 16;
  localparam int BUDGET = 3000;

  logic        clk48mhz = 1'b0;
  logic        rst_n;
  logic        start;
  logic        clk_mod;
  logic        cmd_req;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        cmd_done;
  logic        cmd_timeout;
  logic        cmd_crc_err;
  logic [31:0] cmd_resp;
  logic        init_busy;
  logic        init_done;
  logic        init_err;
  logic [2:0]  err_code;
  logic        sdhc;
  logic [15:0] rca;

  // 48 MHz system clock (period rounded to 10 time units).
  always #5 clk48mhz = ~clk48mhz;

  sd_init_ctrl #(
    .POWERUP_CYCLES(PWR),
    .ACMD41_RETRY  (RETRY),
    .SWITCH_GUARD  (GUARD)
  ) dut (
    .clk48mhz   (clk48mhz),
    .rst_n      (rst_n),
    .start      (start),
    .clk_mod    (clk_mod),
    .cmd_req    (cmd_req),
    .cmd_index  (cmd_index),
    .cmd_arg    (cmd_arg),
    .cmd_done   (cmd_done),
    .cmd_timeout(cmd_timeout),
    .cmd_crc_err(cmd_crc_err),
    .cmd_resp   (cmd_resp),
    .init_busy  (init_busy),
    .init_done  (init_done),
    .init_err   (init_err),
    .err_code   (err_code),
    .sdhc       (sdhc),
    .rca        (rca)
  );

  // cmd8Mode: 0 echo 0x1AA, 1 timeout, 2 echo 0x0AA.
  // faultKind on faultIdx: 1 timeout, 2 done+timeout, 3 done+crc (63 = no fault).
  typedef struct {
    string       name;
    int          cmd8Mode;
    int          acmdBusy;
    logic [31:0] acmdResp;
    logic [31:0] cmd3Resp;
    int          faultIdx;
    int          faultKind;
    bit          abortAt41;
    bit          expDone;
    logic [2:0]  expCode;
    bit          expSdhc;
    logic [15:0] expRca;
    int          expAcmd;
    logic [31:0] expAcmdArg;
    logic [31:0] expCmd7Arg;
  } vec_t;

  vec_t vecs[11];
  vec_t vAbort;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int          nAcmd, n16, firstReqCyc, lastRespCyc, endCyc, startCyc;
  logic [31:0] seenAcmdArg, seenCmd7Arg, seen16Arg;
  bit          timedOut, overlap, aborted;

  task automatic tick();
    @(negedge clk48mhz);
    cyc++;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ".clk_mod"},   32'(clk_mod),   32'd0);
    checkOutput({tag, ".cmd_req"},   32'(cmd_req),   32'd0);
    checkOutput({tag, ".cmd_index"}, 32'(cmd_index), 32'd0);
    checkOutput({tag, ".cmd_arg"},   cmd_arg,        32'd0);
    checkOutput({tag, ".busy"},      32'(init_busy), 32'd0);
    checkOutput({tag, ".done"},      32'(init_done), 32'd0);
    checkOutput({tag, ".err"},       32'(init_err),  32'd0);
    checkOutput({tag, ".err_code"},  32'(err_code),  32'd0);
    checkOutput({tag, ".sdhc"},      32'(sdhc),      32'd0);
    checkOutput({tag, ".rca"},       32'(rca),       32'd0);
  endtask

  // Pulse start, then act as the command engine until DONE/ERR, abort or budget.
  task automatic applyStimulus(input vec_t v);
    int          busyLeft;
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [31:0] resp;
    bit          dn, to, crc;
    busyLeft    = v.acmdBusy;
    nAcmd       = 0;
    n16         = 0;
    firstReqCyc = -1;
    lastRespCyc = 0;
    endCyc      = 0;
    seenAcmdArg = 32'h0;
    seenCmd7Arg = 32'h0;
    seen16Arg   = 32'h0;
    timedOut    = 1'b0;
    overlap     = 1'b0;
    aborted     = 1'b0;
    start    = 1'b1;
    startCyc = cyc;
    tick();
    start = 1'b0;
    checkOutput({v.name, ".busyAfterStart"}, 32'(init_busy), 32'd1);
    while (1) begin
      tick();
      if (cmd_req && clk_mod) overlap = 1'b1;
      if (init_done || init_err) begin
        endCyc = cyc;
        break;
      end
      if (cyc - startCyc > BUDGET) begin
        timedOut = 1'b1;
        break;
      end
      if (cmd_req) begin
        if (firstReqCyc < 0) firstReqCyc = cyc;
        idx = cmd_index;
        arg = cmd_arg;
        if (v.abortAt41 && idx == 6'd41) begin
          rst_n = 1'b0;
          #1;
          aborted = 1'b1;
          break;
        end
        dn   = 1'b1;
        to   = 1'b0;
        crc  = 1'b0;
        resp = 32'h0;
        case (idx)
          6'd8: begin
            if (v.cmd8Mode == 1) begin
              dn = 1'b0;
              to = 1'b1;
            end else begin
              resp = (v.cmd8Mode == 2) ? 32'h0000_00AA : 32'h0000_01AA;
            end
          end
          6'd55: resp = 32'h0000_0120;
          6'd41: begin
            nAcmd++;
            seenAcmdArg = arg;
            if (busyLeft > 0) begin
              busyLeft--;
              resp = 32'h00FF_8000;
            end else begin
              resp = v.acmdResp;
            end
          end
          6'd3:  resp = v.cmd3Resp;
          6'd7:  seenCmd7Arg = arg;
          6'd16: begin
            n16++;
            seen16Arg = arg;
          end
          default: ;
        endcase
        if (int'(idx) == v.faultIdx) begin
          case (v.faultKind)
            1: begin dn = 1'b0; to = 1'b1; end
            2: begin dn = 1'b1; to = 1'b1; end
            3: begin dn = 1'b1; crc = 1'b1; end
            default: ;
          endcase
        end
        repeat (2) tick();
        cmd_done    = dn;
        cmd_timeout = to;
        cmd_crc_err = crc;
        cmd_resp    = resp;
        lastRespCyc = cyc;
        tick();
        cmd_done    = 1'b0;
        cmd_timeout = 1'b0;
        cmd_crc_err = 1'b0;
        cmd_resp    = 32'h0;
      end
    end
  endtask

  task automatic checkResult(input vec_t v);
    int exp16;
`ifdef SD_INIT_CMD16_EN
    exp16 = (v.expDone && !v.expSdhc) ? 1 : 0;
`else
    exp16 = 0;
`endif
    checkOutput({v.name, ".timedOut"},  32'(timedOut),                32'd0);
    checkOutput({v.name, ".pwrupLen"},  32'(firstReqCyc - startCyc),  32'(PWR + 1));
    checkOutput({v.name, ".done"},      32'(init_done),               32'(v.expDone));
    checkOutput({v.name, ".err"},       32'(init_err),                32'(!v.expDone));
    checkOutput({v.name, ".err_code"},  32'(err_code),                32'(v.expCode));
    checkOutput({v.name, ".sdhc"},      32'(sdhc),                    32'(v.expSdhc));
    checkOutput({v.name, ".rca"},       32'(rca),                     32'(v.expRca));
    checkOutput({v.name, ".clk_mod"},   32'(clk_mod),                 32'(v.expDone));
    checkOutput({v.name, ".cmd_req"},   32'(cmd_req),                 32'd0);
    checkOutput({v.name, ".busy"},      32'(init_busy),               32'd0);
    checkOutput({v.name, ".nAcmd41"},   32'(nAcmd),                   32'(v.expAcmd));
    checkOutput({v.name, ".acmd41Arg"}, seenAcmdArg,                  v.expAcmdArg);
    checkOutput({v.name, ".cmd7Arg"},   seenCmd7Arg,                  v.expCmd7Arg);
    checkOutput({v.name, ".nCmd16"},    32'(n16),                     32'(exp16));
    checkOutput({v.name, ".cmd16Arg"},  seen16Arg,                    (exp16 != 0) ? 32'h200 : 32'h0);
    checkOutput({v.name, ".clkModWithReq"}, 32'(overlap),             32'd0);
    if (v.expDone)
      checkOutput({v.name, ".guardLen"}, 32'(endCyc - lastRespCyc),   32'(GUARD + 1));
  endtask

  // Hard stop in case the design wedges the simulation.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Main sequence: reset, table scenarios, then the multi-cycle corner cases.
  initial begin
    vecs[0]  = '{"v2sdhc",          0,  2, 32'hC0FF8000, 32'h12340000, 63, 0, 1'b0, 1'b1, 3'd0, 1'b1, 16'h1234, 3, 32'h40FF8000, 32'h12340000};
    vecs[1]  = '{"v1card",          1,  0, 32'h80FF8000, 32'hABCD0000, 63, 0, 1'b0, 1'b1, 3'd0, 1'b0, 16'hABCD, 1, 32'h00FF8000, 32'hABCD0000};
    vecs[2]  = '{"badEcho",         2,  0, 32'hC0FF8000, 32'h12340000, 63, 0, 1'b0, 1'b0, 3'd1, 1'b0, 16'h0000, 0, 32'h0,        32'h0};
    vecs[3]  = '{"acmdExhaust",     0, 99, 32'hC0FF8000, 32'h12340000, 63, 0, 1'b0, 1'b0, 3'd2, 1'b0, 16'h0000, 4, 32'h40FF8000, 32'h0};
    vecs[4]  = '{"cmd3DoneTimeout", 0,  0, 32'hC0FF8000, 32'h99990000,  3, 2, 1'b0, 1'b0, 3'd3, 1'b1, 16'h0000, 1, 32'h40FF8000, 32'h0};
    vecs[5]  = '{"cmd7Crc",         0,  1, 32'hC0FF8000, 32'h56780000,  7, 3, 1'b0, 1'b0, 3'd4, 1'b1, 16'h5678, 2, 32'h40FF8000, 32'h56780000};
    vecs[6]  = '{"cmd2CrcIgnored",  0,  0, 32'h80FF8000, 32'h00010000,  2, 3, 1'b0, 1'b1, 3'd0, 1'b0, 16'h0001, 1, 32'h40FF8000, 32'h00010000};
    vecs[7]  = '{"cmd0Timeout",     0,  0, 32'hC0FF8000, 32'h12340000,  0, 1, 1'b0, 1'b0, 3'd3, 1'b0, 16'h0000, 0, 32'h0,        32'h0};
    vecs[8]  = '{"cmd8Crc",         0,  0, 32'hC0FF8000, 32'h12340000,  8, 3, 1'b0, 1'b0, 3'd4, 1'b0, 16'h0000, 0, 32'h0,        32'h0};
    vecs[9]  = '{"acmdCrcIgnored",  1,  1, 32'hC0FF8000, 32'h0BEE0000, 41, 3, 1'b0, 1'b1, 3'd0, 1'b1, 16'h0BEE, 2, 32'h00FF8000, 32'h0BEE0000};
    vecs[10] = '{"cmd55Timeout",    0,  0, 32'hC0FF8000, 32'h12340000, 55, 1, 1'b0, 1'b0, 3'd3, 1'b0, 16'h0000, 0, 32'h0,        32'h0};
    vAbort   = '{"abortAcmd41",     0,  0, 32'hC0FF8000, 32'h12340000, 63, 0, 1'b1, 1'b0, 3'd0, 1'b0, 16'h0000, 0, 32'h0,        32'h0};

    rst_n       = 1'b0;
    start       = 1'b0;
    cmd_done    = 1'b0;
    cmd_timeout = 1'b0;
    cmd_crc_err = 1'b0;
    cmd_resp    = 32'h0;
    repeat (3) tick();
    checkResetOutputs("reset");
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i]);
      checkResult(vecs[i]);
      tick();
    end

    // A second start pulse during power-up must not restart the sequence.
    start    = 1'b1;
    startCyc = cyc;
    tick();
    start = 1'b0;
    repeat (5) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    firstReqCyc = -1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (cmd_req) begin
        firstReqCyc = cyc;
        break;
      end
    end
    checkOutput("startIgnored.firstReq", 32'(firstReqCyc - startCyc), 32'(PWR + 1));
    checkOutput("startIgnored.index",    32'(cmd_index),              32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Reset asserted while ACMD41 is outstanding, then a clean rerun.
    applyStimulus(vAbort);
    checkOutput("abort.reached", 32'(aborted), 32'd1);
    checkResetOutputs("abort");
    tick();
    rst_n = 1'b1;
    tick();
    applyStimulus(vecs[0]);
    checkResult(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
